// File: rtl/uart_pkg.sv
// Shared types for the UART RX frame checker: frame FSM states and parity-type encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter; holds at all-ones, synchronous clear takes priority over increment.
// Single cycle update, no backpressure.
module sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != {WIDTH{1'b1}})) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/frame_chk.sv
// UART RX frame checker: start/parity/stop checking, word assembly, saturating error counters.
// Results land 1 CLK after the last stop strobe, no backpressure; BREAK_DET_EN adds brk_det.
module frame_chk
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  bit_strb,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  cnt_clr,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_err,
`ifdef BREAK_DET_EN
    output logic                  brk_det,
`endif
    output logic [ERR_CNT_W-1:0]  par_err_cnt,
    output logic [ERR_CNT_W-1:0]  stp_err_cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    frame_state_t          state, state_nxt;
    logic [BW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q, par_typ_q;
    logic                  par_acc, stp_acc;
    logic                  done_set, strt_set;
    logic                  stp_now;
    logic                  par_inc, stp_inc;

    assign busy    = (state != IDLE);
    assign stp_now = stp_acc | ~sampled_bit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // frame_start outranks everything, so a coincident strobe is simply never consumed.
    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        strt_set  = 1'b0;
        if (frame_start) begin
            state_nxt = START;
        end else begin
            case (state)
                IDLE: ;
                START: if (bit_strb) begin
                    if (sampled_bit) begin
                        state_nxt = IDLE;
                        strt_set  = 1'b1;
                    end else begin
                        state_nxt = DATA;
                    end
                end
                DATA: if (bit_strb && (bit_cnt == LAST_BIT))
                    state_nxt = par_en_q ? PARITY : STOP;
                PARITY: if (bit_strb) state_nxt = STOP;
                STOP: if (bit_strb && (stop_cnt == LAST_STOP)) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_acc    <= 1'b0;
            stp_acc    <= 1'b0;
            frame_done <= 1'b0;
            strt_err   <= 1'b0;
            data_out   <= '0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            frame_done <= done_set;
            strt_err   <= strt_set;
            if (frame_start) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                par_acc   <= 1'b0;
                stp_acc   <= 1'b0;
            end else if (bit_strb) begin
                case (state)
                    DATA: begin
                        shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_acc <= ((^shreg) ^ sampled_bit) != (par_typ_q == PAR_ODD);
                    STOP: begin
                        stop_cnt <= stop_cnt + 1'b1;
                        stp_acc  <= stp_now;
                    end
                    default: ;
                endcase
            end
            if (done_set) begin
                data_out <= shreg;
                par_err  <= par_en_q & par_acc;
                stp_err  <= stp_now;
            end
        end
    end

    assign par_inc = done_set & par_en_q & par_acc;

`ifdef BREAK_DET_EN
    // Tracks whether any frame bit (start through stop) was seen high.
    logic ones_acc;
    logic brk_now;

    assign brk_now = ~(ones_acc | sampled_bit);
    assign stp_inc = done_set & stp_now & ~brk_now;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ones_acc <= 1'b0;
            brk_det  <= 1'b0;
        end else begin
            brk_det <= done_set & brk_now;
            if (frame_start)
                ones_acc <= 1'b0;
            else if (bit_strb && (state != IDLE))
                ones_acc <= ones_acc | sampled_bit;
        end
    end
`else
    assign stp_inc = done_set & stp_now;
`endif

    sat_cnt #(.WIDTH(ERR_CNT_W)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (par_inc),
        .clr   (cnt_clr),
        .value (par_err_cnt)
    );

    sat_cnt #(.WIDTH(ERR_CNT_W)) u_stp_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stp_inc),
        .clr   (cnt_clr),
        .value (stp_err_cnt)
    );

endmodule

// File: tb/tb_frame_chk.sv
// Directed bench for frame_chk (DATA_WIDTH=8, STOP_BITS=2, ERR_CNT_W=2).
module tb_frame_chk;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       frame_start = 1'b0;
    logic       bit_strb = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       busy, frame_done, par_err, stp_err, strt_err;
    logic [7:0] data_out;
    logic [1:0] par_err_cnt, stp_err_cnt;
`ifdef BREAK_DET_EN
    logic       brk_det;
    logic       cap_brk = 1'b0;
`endif

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;
    int strt_cnt = 0;

    always #5 CLK = ~CLK;

    frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_start (frame_start),
        .bit_strb    (bit_strb),
        .sampled_bit (sampled_bit),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .cnt_clr     (cnt_clr),
        .busy        (busy),
        .frame_done  (frame_done),
        .data_out    (data_out),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_err    (strt_err),
`ifdef BREAK_DET_EN
        .brk_det     (brk_det),
`endif
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    // Pulse tally, sampled mid-cycle.
    always @(negedge CLK) begin
        if (frame_done) done_cnt++;
        if (strt_err)   strt_cnt++;
`ifdef BREAK_DET_EN
        if (frame_done) cap_brk = brk_det;
`endif
    end

    task automatic send_bit(input logic b, input logic clr);
        bit_strb = 1'b1; sampled_bit = b; cnt_clr = clr;
        @(posedge CLK); #1;
        bit_strb = 1'b0; sampled_bit = 1'b1; cnt_clr = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic start_frame(input logic pe, input logic pt);
        frame_start = 1'b1; par_en = pe; par_typ = pt;
        @(posedge CLK); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pb, input logic s0, input logic s1, input logic clr_last);
        start_frame(pe, pt);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        if (pe) send_bit(pb, 1'b0);
        send_bit(s0, 1'b0);
        send_bit(s1, clr_last);
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge CLK); #1;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        checks++; if (frame_done !== 1'b0 || strt_err !== 1'b0) $display("FAIL rst_pulses: got %b%b want 00", frame_done, strt_err); else passed++;
        checks++; if (data_out !== 8'h00 || par_err !== 1'b0 || stp_err !== 1'b0) $display("FAIL rst_outs: got %h %b %b want 00 0 0", data_out, par_err, stp_err); else passed++;
        checks++; if (par_err_cnt !== 2'd0 || stp_err_cnt !== 2'd0) $display("FAIL rst_cnts: got %0d %0d want 0 0", par_err_cnt, stp_err_cnt); else passed++;
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_no_parity();
        logic [7:0] d;
        d = 8'h5A;
        start_frame(1'b0, 1'b0);
        checks++; if (busy !== 1'b1) $display("FAIL np_busy: got %b want 1", busy); else passed++;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(1'b1, 1'b0);
        bit_strb = 1'b1; sampled_bit = 1'b1;
        @(posedge CLK); #1;
        bit_strb = 1'b0;
        checks++; if (frame_done !== 1'b1) $display("FAIL np_latency: got %b want 1", frame_done); else passed++;
        @(posedge CLK); #1;
        checks++; if (frame_done !== 1'b0) $display("FAIL np_pulse: got %b want 0", frame_done); else passed++;
        checks++; if (data_out !== 8'h5A) $display("FAIL np_data: got %h want 5a", data_out); else passed++;
        checks++; if (par_err !== 1'b0 || stp_err !== 1'b0) $display("FAIL np_errs: got %b%b want 00", par_err, stp_err); else passed++;
        checks++; if (par_err_cnt !== 2'd0 || stp_err_cnt !== 2'd0 || busy !== 1'b0) $display("FAIL np_cnts: got %0d %0d busy %b want 0 0 0", par_err_cnt, stp_err_cnt, busy); else passed++;
    endtask

    task automatic test_parity();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (par_err !== 1'b1 || par_err_cnt !== 2'd1) $display("FAIL par_even_bad: got %b cnt %0d want 1 cnt 1", par_err, par_err_cnt); else passed++;
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (par_err !== 1'b0 || par_err_cnt !== 2'd1) $display("FAIL par_even_ok: got %b cnt %0d want 0 cnt 1", par_err, par_err_cnt); else passed++;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (par_err !== 1'b0 || data_out !== 8'h07) $display("FAIL par_odd_ok: got %b %h want 0 07", par_err, data_out); else passed++;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (par_err !== 1'b1 || par_err_cnt !== 2'd2) $display("FAIL par_odd_bad: got %b cnt %0d want 1 cnt 2", par_err, par_err_cnt); else passed++;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (par_err !== 1'b0 || par_err_cnt !== 2'd2 || data_out !== 8'hC3) $display("FAIL par_off: got %b cnt %0d %h want 0 cnt 2 c3", par_err, par_err_cnt, data_out); else passed++;
    endtask

    task automatic test_stop();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (stp_err !== 1'b1 || stp_err_cnt !== 2'd1) $display("FAIL stp_second: got %b cnt %0d want 1 cnt 1", stp_err, stp_err_cnt); else passed++;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (stp_err !== 1'b0 || stp_err_cnt !== 2'd1) $display("FAIL stp_ok: got %b cnt %0d want 0 cnt 1", stp_err, stp_err_cnt); else passed++;
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (stp_err !== 1'b1 || stp_err_cnt !== 2'd2) $display("FAIL stp_first: got %b cnt %0d want 1 cnt 2", stp_err, stp_err_cnt); else passed++;
    endtask

    task automatic test_start_glitch();
        int d0, s0;
        d0 = done_cnt; s0 = strt_cnt;
        start_frame(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++; if (strt_cnt !== s0 + 1) $display("FAIL glitch_pulse: got %0d want %0d", strt_cnt, s0 + 1); else passed++;
        checks++; if (busy !== 1'b0 || done_cnt !== d0) $display("FAIL glitch_idle: busy %b done %0d want 0 %0d", busy, done_cnt, d0); else passed++;
        for (int i = 0; i < 12; i++) send_bit(1'b0, 1'b0);
        checks++; if (busy !== 1'b0 || done_cnt !== d0 || strt_cnt !== s0 + 1) $display("FAIL idle_strb: busy %b done %0d strt %0d want 0 %0d %0d", busy, done_cnt, strt_cnt, d0, s0 + 1); else passed++;
    endtask

    task automatic test_restart();
        int d0, s0;
        logic [7:0] d;
        d = 8'hA5;
        d0 = done_cnt; s0 = strt_cnt;
        start_frame(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        // Restart with a coincident strobe that must be dropped.
        frame_start = 1'b1; bit_strb = 1'b1; sampled_bit = 1'b0;
        @(posedge CLK); #1;
        frame_start = 1'b0; bit_strb = 1'b0; sampled_bit = 1'b1;
        checks++; if (busy !== 1'b1) $display("FAIL rs_busy: got %b want 1", busy); else passed++;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++; if (done_cnt !== d0 + 1 || strt_cnt !== s0) $display("FAIL rs_count: done %0d strt %0d want %0d %0d", done_cnt, strt_cnt, d0 + 1, s0); else passed++;
        checks++; if (data_out !== 8'hA5 || stp_err !== 1'b0) $display("FAIL rs_data: got %h %b want a5 0", data_out, stp_err); else passed++;
    endtask

    task automatic test_saturation();
        pulse_clr();
        checks++; if (stp_err_cnt !== 2'd0 || par_err_cnt !== 2'd0) $display("FAIL sat_clr: got %0d %0d want 0 0", stp_err_cnt, par_err_cnt); else passed++;
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (stp_err_cnt !== 2'd2) $display("FAIL sat_two: got %0d want 2", stp_err_cnt); else passed++;
        for (int i = 0; i < 3; i++) send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (stp_err_cnt !== 2'd3) $display("FAIL sat_hold: got %0d want 3", stp_err_cnt); else passed++;
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (stp_err_cnt !== 2'd0 || stp_err !== 1'b1) $display("FAIL sat_clr_wins: got %0d %b want 0 1", stp_err_cnt, stp_err); else passed++;
    endtask

    task automatic test_break();
`ifdef BREAK_DET_EN
        pulse_clr();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cap_brk !== 1'b1 || stp_err !== 1'b1 || stp_err_cnt !== 2'd0) $display("FAIL brk_zero: brk %b stp %b cnt %0d want 1 1 0", cap_brk, stp_err, stp_err_cnt); else passed++;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cap_brk !== 1'b0 || stp_err_cnt !== 2'd1) $display("FAIL brk_none: brk %b cnt %0d want 0 1", cap_brk, stp_err_cnt); else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (data_out !== 8'h33 || stp_err !== 1'b1 || par_err !== 1'b1) $display("FAIL rm_pre: got %h %b %b want 33 1 1", data_out, stp_err, par_err); else passed++;
        start_frame(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        RST = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || strt_err !== 1'b0) $display("FAIL rm_state: got %b%b%b want 000", busy, frame_done, strt_err); else passed++;
        checks++; if (data_out !== 8'h00 || stp_err !== 1'b0 || par_err !== 1'b0) $display("FAIL rm_outs: got %h %b %b want 00 0 0", data_out, stp_err, par_err); else passed++;
        checks++; if (stp_err_cnt !== 2'd0 || par_err_cnt !== 2'd0) $display("FAIL rm_cnts: got %0d %0d want 0 0", stp_err_cnt, par_err_cnt); else passed++;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_stop();
        test_start_glitch();
        test_restart();
        test_saturation();
        test_break();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
